// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: round-robin arbiter for four DMA masters on a shared bus.
// A registered request snapshot is arbitrated in IDLE and the winner gets a
// one-cycle grant pulse. The arbiter then follows the bus begin/end handshake.
// Optional watchdog: define ARBITER_TIMEOUT_EN to bound WAIT_BEGIN/BUSY at
// TIMEOUT_CYCLES and to force an end+error when BUSY times out.
module dma_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] requestVector,
  input  logic       beginTransactionIn,
  input  logic       endTransactionIn,
  input  logic       busErrorIn,
  output logic [3:0] grantVector,
  output logic [1:0] activeMaster,
  output logic       busBusy,
  output logic       endTransactionOut,
  output logic       busErrorOut
);

  // The watchdog is an 8-bit counter, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("dma_bus_arbiter: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    WAIT_BEGIN,
    BUSY
`ifdef ARBITER_TIMEOUT_EN
    , FORCE_END
`endif
  } state_t;

  state_t     state_q;
  logic [3:0] req_q;
  logic [1:0] lastGranted_q;
  logic [3:0] grantVector_q;
  logic [1:0] activeMaster_q;
  logic       busBusy_q;
  logic [1:0] winner_d;
  logic [1:0] rrIdx;
  logic       found;

`ifdef ARBITER_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] wdog_q;
  logic       endTransactionOut_q;
  logic       busErrorOut_q;
`endif

  // Round-robin pick: scan upward from the master after the last grant.
  always_comb begin
    winner_d = lastGranted_q;
    rrIdx    = lastGranted_q;
    found    = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      rrIdx = lastGranted_q + 2'(i);
      if (!found && req_q[rrIdx]) begin
        winner_d = rrIdx;
        found    = 1'b1;
      end
    end
  end

  // Arbiter FSM with all outputs registered alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      req_q          <= '0;
      lastGranted_q  <= 2'd3;
      grantVector_q  <= '0;
      activeMaster_q <= '0;
      busBusy_q      <= 1'b0;
`ifdef ARBITER_TIMEOUT_EN
      wdog_q              <= '0;
      endTransactionOut_q <= 1'b0;
      busErrorOut_q       <= 1'b0;
`endif
    end else begin
      req_q         <= requestVector;
      grantVector_q <= '0;
`ifdef ARBITER_TIMEOUT_EN
      endTransactionOut_q <= 1'b0;
      busErrorOut_q       <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (found) begin
            state_q        <= GRANT;
            grantVector_q  <= 4'b0001 << winner_d;
            activeMaster_q <= winner_d;
            lastGranted_q  <= winner_d;
            busBusy_q      <= 1'b1;
          end
        end
        GRANT: begin
          state_q <= WAIT_BEGIN;
`ifdef ARBITER_TIMEOUT_EN
          wdog_q  <= '0;
`endif
        end
        WAIT_BEGIN: begin
          if (beginTransactionIn && endTransactionIn) begin
            state_q   <= IDLE;
            busBusy_q <= 1'b0;
          end else if (beginTransactionIn) begin
            state_q <= BUSY;
`ifdef ARBITER_TIMEOUT_EN
            wdog_q  <= '0;
          end else if (wdog_q >= TIMEOUT_LIMIT) begin
            state_q   <= IDLE;
            busBusy_q <= 1'b0;
          end else begin
            wdog_q <= wdog_q + 8'd1;
`endif
          end
        end
        BUSY: begin
          if (endTransactionIn) begin
            state_q   <= IDLE;
            busBusy_q <= 1'b0;
`ifdef ARBITER_TIMEOUT_EN
          end else if (wdog_q >= TIMEOUT_LIMIT) begin
            state_q             <= FORCE_END;
            endTransactionOut_q <= 1'b1;
            busErrorOut_q       <= 1'b1;
          end else begin
            wdog_q <= wdog_q + 8'd1;
            // An error without an end keeps the master on the bus.
            if (busErrorIn) state_q <= BUSY;
`else
          end else if (busErrorIn) begin
            // An error without an end keeps the master on the bus.
            state_q <= BUSY;
`endif
          end
        end
`ifdef ARBITER_TIMEOUT_EN
        FORCE_END: begin
          state_q   <= IDLE;
          busBusy_q <= 1'b0;
        end
`endif
        default: begin
          state_q   <= IDLE;
          busBusy_q <= 1'b0;
        end
      endcase
    end
  end

  assign grantVector  = grantVector_q;
  assign activeMaster = activeMaster_q;
  assign busBusy      = busBusy_q;

`ifdef ARBITER_TIMEOUT_EN
  assign endTransactionOut = endTransactionOut_q;
  assign busErrorOut       = busErrorOut_q;
`else
  assign endTransactionOut = 1'b0;
  assign busErrorOut       = 1'b0;
`endif

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Bench for dma_bus_arbiter: vector table plus hand-written multi-cycle
// sequences; expectations go through a scoreboard queue.
module tb_dma_bus_arbiter;

`ifdef ARBITER_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] requestVector;
  logic       beginTransactionIn;
  logic       endTransactionIn;
  logic       busErrorIn;
  logic [3:0] grantVector;
  logic [1:0] activeMaster;
  logic       busBusy;
  logic       endTransactionOut;
  logic       busErrorOut;

  always #5 clock = ~clock;

  dma_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clock             (clock),
    .reset             (reset),
    .requestVector     (requestVector),
    .beginTransactionIn(beginTransactionIn),
    .endTransactionIn  (endTransactionIn),
    .busErrorIn        (busErrorIn),
    .grantVector       (grantVector),
    .activeMaster      (activeMaster),
    .busBusy           (busBusy),
    .endTransactionOut (endTransactionOut),
    .busErrorOut       (busErrorOut)
  );

  typedef struct {
    logic [3:0] req;
    logic       beg;
    logic       endt;
    logic       err;
    logic [3:0] g;
    logic [1:0] a;
    logic       b;
  } vec_t;

  typedef struct {
    logic [8:0] v;
    string      tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic [3:0] req, input logic beg, input logic endt,
                     input logic err, input logic [3:0] g, input logic [1:0] a,
                     input logic b);
    vec_t v;
    v.req = req; v.beg = beg; v.endt = endt; v.err = err;
    v.g = g; v.a = a; v.b = b;
    tbl.push_back(v);
  endtask

  task automatic check_out();
    exp_t       e;
    logic [8:0] act;
    e   = sbq.pop_front();
    act = {grantVector, activeMaster, busBusy, endTransactionOut, busErrorOut};
    total++;
    if (act !== e.v) begin
      bad++;
      $display("FAIL %s: got grant=%b active=%0d busy=%b eto=%b beo=%b, want grant=%b active=%0d busy=%b eto=%b beo=%b",
               e.tag, act[8:5], act[4:3], act[2], act[1], act[0],
               e.v[8:5], e.v[4:3], e.v[2], e.v[1], e.v[0]);
    end
  endtask

  // One clock: drive inputs, queue the expected outputs, compare after the edge.
  task automatic cyc(input string tag, input logic rst, input logic [3:0] req,
                     input logic beg, input logic endt, input logic err,
                     input logic [3:0] g, input logic [1:0] a, input logic b,
                     input logic eto, input logic beo);
    exp_t e;
    reset              = rst;
    requestVector      = req;
    beginTransactionIn = beg;
    endTransactionIn   = endt;
    busErrorIn         = err;
    e.v   = {g, a, b, eto, beo};
    e.tag = tag;
    sbq.push_back(e);
    @(posedge clock);
    #1;
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] g;
    logic [1:0] m;

    reset = 1'b1; requestVector = '0;
    beginTransactionIn = 1'b0; endTransactionIn = 1'b0; busErrorIn = 1'b0;

    //  req    beg end err  grant   act  busy
    add(4'b0101, 0, 0, 0, 4'b0000, 2'd0, 0);
    add(4'b0101, 0, 0, 0, 4'b0001, 2'd0, 1);
    add(4'b0100, 0, 0, 0, 4'b0000, 2'd0, 1);
    add(4'b0100, 1, 0, 0, 4'b0000, 2'd0, 1);
    add(4'b0100, 0, 0, 0, 4'b0000, 2'd0, 1);
    add(4'b0100, 0, 1, 0, 4'b0000, 2'd0, 0);
    add(4'b0100, 0, 0, 0, 4'b0100, 2'd2, 1);
    add(4'b0000, 0, 0, 0, 4'b0000, 2'd2, 1);
    add(4'b0000, 1, 1, 0, 4'b0000, 2'd2, 0);
    add(4'b0000, 0, 0, 0, 4'b0000, 2'd2, 0);
    add(4'b1000, 0, 0, 0, 4'b0000, 2'd2, 0);
    add(4'b1000, 0, 0, 0, 4'b1000, 2'd3, 1);
    add(4'b0000, 0, 0, 0, 4'b0000, 2'd3, 1);
    add(4'b0000, 1, 0, 0, 4'b0000, 2'd3, 1);
    add(4'b0000, 0, 0, 1, 4'b0000, 2'd3, 1);
    add(4'b0000, 0, 0, 1, 4'b0000, 2'd3, 1);
    add(4'b0000, 0, 1, 0, 4'b0000, 2'd3, 0);
    add(4'b0001, 0, 0, 0, 4'b0000, 2'd3, 0);
    add(4'b0001, 0, 0, 0, 4'b0001, 2'd0, 1);
    add(4'b0000, 0, 0, 0, 4'b0000, 2'd0, 1);
    add(4'b0010, 1, 0, 0, 4'b0000, 2'd0, 1);
    add(4'b0010, 0, 1, 1, 4'b0000, 2'd0, 0);
    add(4'b0010, 0, 0, 0, 4'b0010, 2'd1, 1);
    add(4'b0000, 0, 0, 0, 4'b0000, 2'd1, 1);
    add(4'b0000, 1, 0, 0, 4'b0000, 2'd1, 1);
    add(4'b0000, 0, 1, 0, 4'b0000, 2'd1, 0);

    cyc("reset0", 1, 4'b1111, 0, 0, 0, 4'b0000, 2'd0, 0, 0, 0);
    cyc("reset1", 1, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++)
      cyc($sformatf("row%0d", i), 0, tbl[i].req, tbl[i].beg, tbl[i].endt,
          tbl[i].err, tbl[i].g, tbl[i].a, tbl[i].b, 0, 0);

    // Reset while BUSY aborts with no forced pulses.
    cyc("rb_idle",  0, 4'b0001, 0, 0, 0, 4'b0000, 2'd1, 0, 0, 0);
    cyc("rb_grant", 0, 4'b0001, 0, 0, 0, 4'b0001, 2'd0, 1, 0, 0);
    cyc("rb_wait",  0, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 1, 0, 0);
    cyc("rb_busy",  0, 4'b0000, 1, 0, 0, 4'b0000, 2'd0, 1, 0, 0);
    cyc("rb_rst",   1, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 0, 0, 0);
    cyc("rb_after", 0, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 0, 0, 0);

    // All four requesting: grants rotate 0,1,2,3,0 starting fresh from reset.
    cyc("rr_idle", 0, 4'b1111, 0, 0, 0, 4'b0000, 2'd0, 0, 0, 0);
    for (int t = 0; t < 5; t++) begin
      m = 2'(t % 4);
      g = 4'b0001 << m;
      cyc($sformatf("rr_grant%0d", t), 0, 4'b1111, 0, 0, 0, g, m, 1, 0, 0);
      cyc($sformatf("rr_wait%0d", t),  0, 4'b1111, 0, 0, 0, 4'b0000, m, 1, 0, 0);
      cyc($sformatf("rr_busy%0d", t),  0, 4'b1111, 1, 0, 0, 4'b0000, m, 1, 0, 0);
      cyc($sformatf("rr_end%0d", t),   0, (t == 4) ? 4'b0000 : 4'b1111,
          0, 1, 0, 4'b0000, m, 0, 0, 0);
    end

    // Single requester: re-granted every round after exactly one idle cycle.
    cyc("one_idle", 0, 4'b0010, 0, 0, 0, 4'b0000, 2'd0, 0, 0, 0);
    for (int r = 0; r < 3; r++) begin
      cyc($sformatf("one_grant%0d", r), 0, 4'b0010, 0, 0, 0, 4'b0010, 2'd1, 1, 0, 0);
      cyc($sformatf("one_wait%0d", r),  0, 4'b0000, 0, 0, 0, 4'b0000, 2'd1, 1, 0, 0);
      cyc($sformatf("one_busy%0d", r),  0, 4'b0000, 1, 0, 0, 4'b0000, 2'd1, 1, 0, 0);
      cyc($sformatf("one_end%0d", r),   0, (r == 2) ? 4'b0000 : 4'b0010,
          0, 1, 0, 4'b0000, 2'd1, 0, 0, 0);
    end

`ifdef ARBITER_TIMEOUT_EN
    // BUSY with no end: forced end+error nine cycles after BUSY entry.
    cyc("tb_idle",  0, 4'b0001, 0, 0, 0, 4'b0000, 2'd1, 0, 0, 0);
    cyc("tb_grant", 0, 4'b0001, 0, 0, 0, 4'b0001, 2'd0, 1, 0, 0);
    cyc("tb_wait",  0, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 1, 0, 0);
    cyc("tb_busy",  0, 4'b0000, 1, 0, 0, 4'b0000, 2'd0, 1, 0, 0);
    for (int k = 1; k <= 8; k++)
      cyc($sformatf("tb_hold%0d", k), 0, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 1, 0, 0);
    cyc("tb_force", 0, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 1, 1, 1);
    cyc("tb_done",  0, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 0, 0, 0);
    // WAIT_BEGIN with no begin: silent return to IDLE.
    cyc("tw_idle",  0, 4'b0001, 0, 0, 0, 4'b0000, 2'd0, 0, 0, 0);
    cyc("tw_grant", 0, 4'b0001, 0, 0, 0, 4'b0001, 2'd0, 1, 0, 0);
    cyc("tw_wait",  0, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 1, 0, 0);
    for (int k = 1; k <= 8; k++)
      cyc($sformatf("tw_hold%0d", k), 0, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 1, 0, 0);
    cyc("tw_drop",  0, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 0, 0, 0);
`else
    // No watchdog: a long wait for begin never releases the bus.
    cyc("uw_idle",  0, 4'b0001, 0, 0, 0, 4'b0000, 2'd1, 0, 0, 0);
    cyc("uw_grant", 0, 4'b0001, 0, 0, 0, 4'b0001, 2'd0, 1, 0, 0);
    for (int k = 0; k < 300; k++)
      cyc($sformatf("uw_wait%0d", k), 0, 4'b0000, 0, 0, 0, 4'b0000, 2'd0, 1, 0, 0);
    cyc("uw_busy",  0, 4'b0000, 1, 0, 0, 4'b0000, 2'd0, 1, 0, 0);
    cyc("uw_end",   0, 4'b0000, 0, 1, 0, 4'b0000, 2'd0, 0, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_bus_arbiter.md
DMA_BUS_ARBITER -- requirements
Module: dma_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum cycles a granted master may spend in WAIT_BEGIN or BUSY before the watchdog fires (8-bit counter).
REQ-002 SHALL have ports, clock and reset first:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- requestVector  in  4  per-master bus request, bit i = master i.
- beginTransactionIn  in  1  shared-bus begin observed.
- endTransactionIn  in  1  shared-bus end observed.
- busErrorIn  in  1  shared-bus error observed.
- grantVector  out  4  one-hot, single-cycle grant pulse.
- activeMaster  out  2  index of the current or last granted master.
- busBusy  out  1  high in every state except IDLE.
- endTransactionOut  out  1  arbiter-forced end on timeout.
- busErrorOut  out  1  arbiter-forced error on timeout.
REQ-003 The reset is synchronous and active-high, named reset; the clock is named clock.

Function
REQ-004 SHALL implement states IDLE, GRANT, WAIT_BEGIN, BUSY and FORCE_END, with all outputs registered.
REQ-005 IDLE: if requestVector != 0, SHALL select a winner by round-robin and go to GRANT; otherwise SHALL stay in IDLE.
REQ-006 Round-robin search SHALL start at (lastGranted+1) mod 4 and proceed upward with wrap-around; lastGranted SHALL update on every grant.
REQ-007 GRANT: grantVector SHALL be one-hot for the winner for exactly one cycle, activeMaster SHALL equal the winner, and the next state SHALL be WAIT_BEGIN.
REQ-008 Request-to-grant latency SHALL be 1 cycle: a request sampled in IDLE at edge N gives a grant pulse during the cycle after edge N+1.
REQ-009 WAIT_BEGIN: beginTransactionIn SHALL go to BUSY.
REQ-010 BUSY: endTransactionIn SHALL go to IDLE.
REQ-011 busErrorIn together with endTransactionIn SHALL go to IDLE.
REQ-012 busErrorIn without endTransactionIn SHALL stay in BUSY until end is seen.
REQ-013 beginTransactionIn and endTransactionIn in the same cycle in WAIT_BEGIN SHALL go to IDLE.
REQ-014 Requests arriving in any non-IDLE state SHALL be ignored; masters hold their request until granted.
REQ-015 Dropping the granted master's request after GRANT SHALL NOT affect the state.
REQ-016 Arbitration SHALL resume in the IDLE cycle following the end, giving one mandatory idle turnaround cycle.
REQ-017 A single requester SHALL be re-granted on every arbitration round.
REQ-018 grantVector SHALL be 0 in every state except GRANT.

Reset
REQ-019 On reset, the state SHALL be IDLE and lastGranted SHALL be 3, so master 0 has first priority.
REQ-020 On reset, grantVector=0, activeMaster=0, busBusy=0, endTransactionOut=0, busErrorOut=0, and the watchdog counter=0.
REQ-021 Reset asserted mid-transaction SHALL abort to IDLE on the next edge without pulsing endTransactionOut or busErrorOut.

Configuration
REQ-022 Macro ARBITER_TIMEOUT_EN enabled: the 8-bit watchdog SHALL clear on entry to WAIT_BEGIN and on entry to BUSY, and SHALL increment every cycle in those states.
REQ-023 If the watchdog reaches TIMEOUT_CYCLES in WAIT_BEGIN, the arbiter SHALL go to IDLE silently.
REQ-024 If the watchdog reaches TIMEOUT_CYCLES in BUSY, the arbiter SHALL go to FORCE_END.
REQ-025 FORCE_END SHALL pulse endTransactionOut=1 and busErrorOut=1 for one cycle, then go to IDLE.
REQ-026 Macro ARBITER_TIMEOUT_EN disabled: there SHALL be no watchdog and no FORCE_END state, endTransactionOut and busErrorOut SHALL be tied to 0, and waits SHALL be unbounded.

Verification
REQ-027 Scenario: reset, then requestVector=4'b0101 -> grantVector=4'b0001, then after end and re-request, grantVector=4'b0100.
REQ-028 Scenario: requestVector=4'b1111 held across 4 transactions -> grant order masters 0,1,2,3, then 0 again.
REQ-029 Scenario: requestVector=4'b0010 only, repeated -> grantVector=4'b0010 each round, with exactly one IDLE cycle between end and the next GRANT.
REQ-030 Scenario: busErrorIn=1 with endTransactionIn=0 in BUSY -> stays BUSY; endTransactionIn=1 two cycles later -> IDLE, busBusy=0.
REQ-031 Scenario, macro on with TIMEOUT_CYCLES=8: grant, begin, no end -> endTransactionOut=1 and busErrorOut=1 for one cycle 9 cycles after BUSY entry, then IDLE.
REQ-032 Scenario: reset asserted in BUSY -> next cycle state=IDLE, all outputs at reset values, no forced pulses.
